// File: rtl/orbit_pkg.sv
// Shared types and helpers for the enemy orbit generator: FSM states,
// default ROM geometry and the quarter-wave quadrant fold.
package orbit_pkg;

  localparam int DEF_SIN_FRAC = 11;
  localparam int DEF_LUT_AW   = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_SIN,
    RD_COS,
    MUL,
    OUT,
    HOLD
  } orbit_state_t;

  typedef struct packed {
    logic neg;
    logic mirror;
  } fold_t;

  // Odd quadrants read the table backwards; the lower half-turn is negated.
  function automatic fold_t quad_fold(input logic [1:0] q);
    fold_t f;
    f.neg    = q[1];
    f.mirror = q[0];
    return f;
  endfunction

endpackage

// File: rtl/orbit_sine_lut.sv
// Quarter-wave sine magnitude ROM, lut[i] = round((2^SIN_FRAC-1)*sin(pi/2*(i+0.5)/N)),
// with a registered read (one cycle latency).
module orbit_sine_lut
  import orbit_pkg::*;
#(
  parameter int LUT_AW   = DEF_LUT_AW,
  parameter int SIN_FRAC = DEF_SIN_FRAC
) (
  input  logic                i_clk,
  input  logic [LUT_AW-1:0]   i_addr,
  output logic [SIN_FRAC-1:0] o_data
);

  localparam int N = 1 << LUT_AW;

  // Elaboration-time Taylor series; the angle never exceeds pi/2 so nine terms are ample.
  function automatic logic [SIN_FRAC-1:0] lut_entry(input int idx);
    real x;
    real term;
    real acc;
    x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(N);
    term = x;
    acc  = x;
    for (int k = 1; k <= 9; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return SIN_FRAC'($rtoi(real'((1 << SIN_FRAC) - 1) * acc + 0.5));
  endfunction

  logic [SIN_FRAC-1:0] w_rom [N];
  logic [SIN_FRAC-1:0] r_data;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
      localparam logic [SIN_FRAC-1:0] C_VAL = lut_entry(gi);
      assign w_rom[gi] = C_VAL;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/enemy_orbit_gen.sv
// Enemy sprite orbit: per frame tick, advance a phase accumulator and emit
// centre + radius*(cos, -sin) on a valid/ready handshake.
module enemy_orbit_gen
  import orbit_pkg::*;
#(
  parameter int POS_W    = 16,
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = DEF_LUT_AW,
  parameter int SIN_FRAC = DEF_SIN_FRAC,
  parameter int RAD_W    = 9,
  parameter int CENTER_X = 320,
  parameter int CENTER_Y = 240,
  parameter int TICK_DIV = 833333
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic [RAD_W-1:0]   radius,
  input  logic [PHASE_W-1:0] phase_step,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic [7:0]         overrun_cnt
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int VAL_W  = SIN_FRAC + 2;
  localparam int PROD_W = RAD_W + 1 + VAL_W;
  localparam int PH_W   = LUT_AW + 2;

  logic [CNT_W-1:0]          r_tick_cnt;
  orbit_state_t              r_state;
  logic                      r_pending;
  logic [7:0]                r_overrun;
  logic [PHASE_W-1:0]        r_phase;
  logic [PH_W-1:0]           r_ph;
  logic [RAD_W-1:0]          r_r;
  logic signed [VAL_W-1:0]   r_sin_val;
  logic signed [PROD_W-1:0]  r_prod_sin;
  logic signed [PROD_W-1:0]  r_prod_cos;
  logic [POS_W-1:0]          r_pos_x;
  logic [POS_W-1:0]          r_pos_y;
  logic                      r_pos_valid;

  logic                      w_tick;
  logic                      w_start;
  logic [1:0]                w_q;
  logic [LUT_AW-1:0]         w_idx;
  fold_t                     w_sin_f;
  fold_t                     w_cos_f;
  logic [LUT_AW-1:0]         w_sin_addr;
  logic [LUT_AW-1:0]         w_cos_addr;
  logic [LUT_AW-1:0]         w_rom_addr;
  logic [SIN_FRAC-1:0]       w_rom_data;
  logic signed [VAL_W-1:0]   w_mag;
  logic signed [VAL_W-1:0]   w_sin_now;
  logic signed [VAL_W-1:0]   w_cos_now;
  logic signed [PROD_W-1:0]  w_r_ext;

  assign w_tick  = enable && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_start = (r_state == IDLE) && (w_tick || r_pending);

  // Only quadrant and table index of the latched phase matter; cos is sin one quadrant on.
  assign w_q        = r_ph[PH_W-1 -: 2];
  assign w_idx      = r_ph[LUT_AW-1:0];
  assign w_sin_f    = quad_fold(w_q);
  assign w_cos_f    = quad_fold(w_q + 2'd1);
  assign w_sin_addr = w_sin_f.mirror ? ~w_idx : w_idx;
  assign w_cos_addr = w_cos_f.mirror ? ~w_idx : w_idx;
  assign w_rom_addr = (r_state == RD_COS) ? w_cos_addr : w_sin_addr;

  assign w_mag     = $signed({2'b00, w_rom_data});
  assign w_sin_now = w_sin_f.neg ? -w_mag : w_mag;
  assign w_cos_now = w_cos_f.neg ? -w_mag : w_mag;
  assign w_r_ext   = PROD_W'($signed({1'b0, r_r}));

  orbit_sine_lut #(
    .LUT_AW   (LUT_AW),
    .SIN_FRAC (SIN_FRAC)
  ) u_lut (
    .i_clk  (CLOCK_50),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_overrun   <= 8'd0;
      r_phase     <= '0;
      r_ph        <= '0;
      r_r         <= '0;
      r_sin_val   <= '0;
      r_prod_sin  <= '0;
      r_prod_cos  <= '0;
      r_pos_x     <= POS_W'(CENTER_X);
      r_pos_y     <= POS_W'(CENTER_Y);
      r_pos_valid <= 1'b0;
    end else begin
      if (!enable || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      // A tick that coincides with a pending start in IDLE becomes the new pending one.
      if (!enable) begin
        r_pending <= 1'b0;
      end else if (r_state == IDLE) begin
        r_pending <= r_pending && w_tick;
      end else if (w_tick) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_ph    <= r_phase[PHASE_W-1 -: PH_W];
            r_r     <= radius;
            r_phase <= r_phase + phase_step;
            r_state <= RD_SIN;
          end
        end
        RD_SIN: r_state <= RD_COS;
        RD_COS: begin
          r_sin_val <= w_sin_now;
          r_state   <= MUL;
        end
        MUL: begin
          r_prod_sin <= w_r_ext * PROD_W'(r_sin_val);
          r_prod_cos <= w_r_ext * PROD_W'(w_cos_now);
          r_state    <= OUT;
        end
        OUT: begin
          r_pos_x     <= POS_W'(CENTER_X + 32'(r_prod_cos >>> SIN_FRAC));
          r_pos_y     <= POS_W'(CENTER_Y - 32'(r_prod_sin >>> SIN_FRAC));
          r_pos_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (pos_ready) begin
            r_pos_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign pos_valid   = r_pos_valid;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_enemy_orbit_gen.sv
// Directed bench for enemy_orbit_gen with a short tick period (TICK_DIV=8);
// expected positions are hand-computed from the fold table and floor shifts.
module tb_enemy_orbit_gen;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pos_ready = 1'b1;
  logic [8:0]  radius = 9'd100;
  logic [15:0] phase_step = 16'h4000;
  logic [15:0] pos_x;
  logic [15:0] pos_y;
  logic        pos_valid;
  logic [7:0]  overrun_cnt;

  int total = 0;
  int bad = 0;

  enemy_orbit_gen #(
    .TICK_DIV (8)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .enable      (enable),
    .radius      (radius),
    .phase_step  (phase_step),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .overrun_cnt (overrun_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Returns the number of edges until pos_valid is seen, or 0 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (pos_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int stable;
    int seen;

    #1 reset = 1'b1;
    #1;
    chk("rst_x", $signed(pos_x), 320);
    chk("rst_y", $signed(pos_y), 240);
    chk("rst_valid", int'(pos_valid), 0);
    chk("rst_ovr", int'(overrun_cnt), 0);

    step();
    step();
    reset  = 1'b0;
    enable = 1'b1;

    // phase 0, then 0x4000, then 0x8000
    wait_valid(40, n);
    chk("lat_first", n, 12);
    chk("x_ph0", $signed(pos_x), 419);
    chk("y_ph0", $signed(pos_y), 240);
    step();
    chk("hs_drop", int'(pos_valid), 0);

    wait_valid(20, n);
    chk("lat_second", n, 7);
    chk("x_ph4000", $signed(pos_x), 319);
    chk("y_ph4000", $signed(pos_y), 141);

    wait_valid(20, n);
    chk("lat_third", n, 8);
    chk("x_ph8000", $signed(pos_x), 220);
    chk("y_ph8000", $signed(pos_y), 241);

    // back-pressure: outputs frozen, first tick pends, the next three overrun
    pos_ready = 1'b0;
    stable = 1;
    repeat (30) begin
      step();
      if (!pos_valid || pos_x != 16'd220 || pos_y != 16'd241) stable = 0;
    end
    chk("hold_stable", stable, 1);
    chk("ovr_three", int'(overrun_cnt), 3);

    pos_ready = 1'b1;
    wait_valid(20, n);
    chk("lat_pending", n, 6);
    chk("x_phC000", $signed(pos_x), 320);
    chk("y_phC000", $signed(pos_y), 340);

    // long stall: overrun saturates
    pos_ready = 1'b0;
    repeat (2100) step();
    chk("ovr_sat", int'(overrun_cnt), 255);
    chk("sat_valid", int'(pos_valid), 1);

    // release, pending start, then reset while the FSM sits in MUL
    pos_ready = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_x", $signed(pos_x), 320);
    chk("mid_rst_y", $signed(pos_y), 240);
    chk("mid_rst_valid", int'(pos_valid), 0);
    chk("mid_rst_ovr", int'(overrun_cnt), 0);
    phase_step = 16'hFFFF;
    step();
    step();
    reset = 1'b0;

    wait_valid(20, n);
    chk("lat_after_rst", n, 12);
    chk("x_after_rst", $signed(pos_x), 419);
    chk("y_after_rst", $signed(pos_y), 240);

    // disabled: no new results, counter restarts from 0
    enable = 1'b0;
    seen = 0;
    repeat (100) begin
      step();
      if (pos_valid) seen++;
    end
    chk("dis_no_valid", seen, 0);

    enable = 1'b1;
    wait_valid(20, n);
    chk("lat_reenable", n, 12);
    chk("x_phFFFF", $signed(pos_x), 419);
    chk("y_phFFFF", $signed(pos_y), 241);

    radius = 9'd50;
    wait_valid(20, n);
    chk("lat_r50", n, 8);
    chk("x_phFFFE_r50", $signed(pos_x), 369);
    chk("y_phFFFE_r50", $signed(pos_y), 241);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
